// File: rtl/io_pkg.sv
// Shared types and constants for the IO write arbiter: FSM encoding, output-port
// addresses, master indices and the output-port address legality check.
`timescale 1ns/1ps
package io_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        GAP_WAIT = 2'd2
    } io_state_t;

    localparam logic [7:0] IO_PORT0_ADDR = 8'h80;
    localparam logic [7:0] IO_PORT1_ADDR = 8'h84;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_AUX = 1'b1;

    // Word address must hit one of the two output ports; byte lanes are ignored.
    function automatic logic io_addr_legal(input logic [31:0] addr);
        return (addr[31:8] == 24'd0) &&
               ((addr[7:2] == IO_PORT0_ADDR[7:2]) || (addr[7:2] == IO_PORT1_ADDR[7:2]));
    endfunction

endpackage

// File: rtl/io_write_arbiter_if.sv
// Request/ready handshakes of both masters plus the write bus toward the output-port register.
`timescale 1ns/1ps
interface io_write_arbiter_if;

    logic        req0_valid;
    logic [31:0] req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;

    logic        req1_valid;
    logic [31:0] req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;

    logic [31:0] io_addr;
    logic [31:0] io_data;
    logic        io_we;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  io_addr, io_data, io_we
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output io_addr, io_data, io_we
    );

endinterface

// File: rtl/io_rr_arb2.sv
// Combinational two-way round-robin grant: on a tie the master that did not win last time wins.
`timescale 1ns/1ps
module io_rr_arb2
    import io_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = valid0 & (~valid1 | (last_grant == MST_AUX));
    assign gnt1 = valid1 & (~valid0 | (last_grant == MST_CPU));

endmodule

// File: rtl/io_write_arbiter.sv
// Shares the output-port register write port between the CPU and aux masters with a settle gap.
// Optional output-port address check is enabled with `define IO_ADDR_CHECK_EN.
`timescale 1ns/1ps
module io_write_arbiter
    import io_pkg::*;
#(
    parameter int GAP   = 2,
    parameter int CNT_W = 16
)
(
    input  logic              io_clk,
    input  logic              clrn,
    io_write_arbiter_if.slave bus,
`ifdef IO_ADDR_CHECK_EN
    input  logic              err_clr,
    output logic              err_addr,
`endif
    output logic              busy,
    output logic [CNT_W-1:0]  wr_cnt0,
    output logic [CNT_W-1:0]  wr_cnt1
);

    localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    io_state_t   state;
    logic        last_grant;
    logic        cur_mst;
    logic        cur_ok;
    logic [3:0]  gap_cnt;
    logic        gnt0;
    logic        gnt1;
    logic        acc0;
    logic        acc1;
    logic        acc_ok;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;

    io_rr_arb2 u_arb (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    assign bus.req0_ready = (state == IDLE) && gnt0;
    assign bus.req1_ready = (state == IDLE) && gnt1;
    assign acc0           = bus.req0_valid & bus.req0_ready;
    assign acc1           = bus.req1_valid & bus.req1_ready;
    assign sel_addr       = acc1 ? bus.req1_addr : bus.req0_addr;
    assign sel_data       = acc1 ? bus.req1_data : bus.req0_data;
    assign busy           = (state != IDLE);

`ifdef IO_ADDR_CHECK_EN
    assign acc_ok = io_addr_legal(sel_addr);
`else
    assign acc_ok = 1'b1;
`endif

    // Rejected addresses still walk through WRITE and the gap, just without the strobe.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            last_grant  <= MST_AUX;
            cur_mst     <= MST_CPU;
            cur_ok      <= 1'b0;
            gap_cnt     <= 4'd0;
            bus.io_addr <= 32'd0;
            bus.io_data <= 32'd0;
            bus.io_we   <= 1'b0;
            wr_cnt0     <= '0;
            wr_cnt1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc0 || acc1) begin
                        bus.io_addr <= sel_addr;
                        bus.io_data <= sel_data;
                        bus.io_we   <= acc_ok;
                        last_grant  <= acc1;
                        cur_mst     <= acc1;
                        cur_ok      <= acc_ok;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    bus.io_we <= 1'b0;
                    if (cur_ok) begin
                        if (cur_mst == MST_AUX) wr_cnt1 <= wr_cnt1 + CNT_ONE;
                        else                    wr_cnt0 <= wr_cnt0 + CNT_ONE;
                    end
                    if (GAP == 0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP_WAIT;
                    end
                end
                GAP_WAIT: begin
                    if (gap_cnt == 4'd0) state <= IDLE;
                    else                 gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IO_ADDR_CHECK_EN
    // A new violation outranks a clear arriving on the same edge.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            err_addr <= 1'b0;
        end else if ((state == IDLE) && (acc0 || acc1) && !acc_ok) begin
            err_addr <= 1'b1;
        end else if (err_clr) begin
            err_addr <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_io_write_arbiter.sv
// Randomized self-checking bench: instance a (GAP=2, 16-bit counters) and instance b
// (GAP=0, 4-bit counters so wrap is reachable) checked every cycle against a timing model.
`timescale 1ns/1ps
module tb_io_write_arbiter;

    localparam int GAP_OF[2]  = '{2, 0};
    localparam int MASK_OF[2] = '{32'hFFFF, 32'hF};

    logic io_clk = 1'b0;
    logic clrn;
    always #5 io_clk = ~io_clk;

    io_write_arbiter_if bus_a ();
    io_write_arbiter_if bus_b ();

    logic        busy_a, busy_b;
    logic [15:0] cnt0_a, cnt1_a;
    logic [3:0]  cnt0_b, cnt1_b;
    logic        err_addr_a, err_addr_b;
    logic        err_clr_a = 1'b0;
    logic        err_clr_b = 1'b0;

    logic        sv[2][2];
    logic [31:0] sa[2][2];
    logic [31:0] sd[2][2];

    assign bus_a.req0_valid = sv[0][0];
    assign bus_a.req0_addr  = sa[0][0];
    assign bus_a.req0_data  = sd[0][0];
    assign bus_a.req1_valid = sv[0][1];
    assign bus_a.req1_addr  = sa[0][1];
    assign bus_a.req1_data  = sd[0][1];
    assign bus_b.req0_valid = sv[1][0];
    assign bus_b.req0_addr  = sa[1][0];
    assign bus_b.req0_data  = sd[1][0];
    assign bus_b.req1_valid = sv[1][1];
    assign bus_b.req1_addr  = sa[1][1];
    assign bus_b.req1_data  = sd[1][1];

    io_write_arbiter #(.GAP(2), .CNT_W(16)) dut_a (
        .io_clk  (io_clk),
        .clrn    (clrn),
        .bus     (bus_a.slave),
`ifdef IO_ADDR_CHECK_EN
        .err_clr (err_clr_a),
        .err_addr(err_addr_a),
`endif
        .busy    (busy_a),
        .wr_cnt0 (cnt0_a),
        .wr_cnt1 (cnt1_a)
    );

    io_write_arbiter #(.GAP(0), .CNT_W(4)) dut_b (
        .io_clk  (io_clk),
        .clrn    (clrn),
        .bus     (bus_b.slave),
`ifdef IO_ADDR_CHECK_EN
        .err_clr (err_clr_b),
        .err_addr(err_addr_b),
`endif
        .busy    (busy_b),
        .wr_cnt0 (cnt0_b),
        .wr_cnt1 (cnt1_b)
    );

`ifndef IO_ADDR_CHECK_EN
    assign err_addr_a = 1'b0;
    assign err_addr_b = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int seq      = 0;

    // Model: a master is idle from free_at on; a write strobes once and counts one cycle later.
    int          free_at[2], we_at[2], last_g[2], pend_m[2];
    int          cnt[2][2], acc_cnt[2][2], quota[2][2];
    bit          accepted[2][2], rnd[2][2], use_bad[2][2];
    logic [31:0] exp_addr[2], exp_data[2];
    int          busy_cyc_a;
    int          we_log_a[$], we_log_b[$], gnt_log_a[$], gnt_cyc_a[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addrLegal(input logic [31:0] addr);
`ifdef IO_ADDR_CHECK_EN
        return ((addr >> 8) == 0) && (((addr >> 2) & 32'h3F) == 32'h20 || ((addr >> 2) & 32'h3F) == 32'h21);
`else
        return (addr == addr);
`endif
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            free_at[k] = cyc; we_at[k] = -100; last_g[k] = 1; pend_m[k] = 0;
            exp_addr[k] = 32'd0; exp_data[k] = 32'd0;
            for (int m = 0; m < 2; m++) begin
                cnt[k][m] = 0; acc_cnt[k][m] = 0; quota[k][m] = 0;
                accepted[k][m] = 1'b0; rnd[k][m] = 1'b0; use_bad[k][m] = 1'b0;
                sv[k][m] = 1'b0; sa[k][m] = 32'd0; sd[k][m] = 32'd0;
            end
        end
    endtask

    task automatic getObs(input int k, output logic r0, output logic r1, output logic we,
                          output logic bz, output logic [31:0] ad, output logic [31:0] dt,
                          output logic [31:0] c0, output logic [31:0] c1);
        if (k == 0) begin
            r0 = bus_a.req0_ready; r1 = bus_a.req1_ready; we = bus_a.io_we; bz = busy_a;
            ad = bus_a.io_addr; dt = bus_a.io_data; c0 = 32'(cnt0_a); c1 = 32'(cnt1_a);
        end else begin
            r0 = bus_b.req0_ready; r1 = bus_b.req1_ready; we = bus_b.io_we; bz = busy_b;
            ad = bus_b.io_addr; dt = bus_b.io_data; c0 = 32'(cnt0_b); c1 = 32'(cnt1_b);
        end
    endtask

    task automatic modelCheck(input int k);
        logic r0, r1, we, bz;
        logic [31:0] ad, dt, c0, c1;
        int g;
        bit idle;
        getObs(k, r0, r1, we, bz, ad, dt, c0, c1);
        if (we_at[k] >= 0 && cyc == we_at[k] + 1)
            cnt[k][pend_m[k]] = (cnt[k][pend_m[k]] + 1) & MASK_OF[k];
        idle = (cyc >= free_at[k]);
        g = -1;
        if (idle) begin
            if (sv[k][0] && sv[k][1]) g = 1 - last_g[k];
            else if (sv[k][0])        g = 0;
            else if (sv[k][1])        g = 1;
        end
        if (k == 0) begin
            if (we) we_log_a.push_back(cyc);
            if (bz) busy_cyc_a++;
            if (r0) begin gnt_log_a.push_back(0); gnt_cyc_a.push_back(cyc); end
            if (r1) begin gnt_log_a.push_back(1); gnt_cyc_a.push_back(cyc); end
        end else if (we) begin
            we_log_b.push_back(cyc);
        end
        checkOutput($sformatf("k%0d_c%0d_ready0", k, cyc), r0, (g == 0));
        checkOutput($sformatf("k%0d_c%0d_ready1", k, cyc), r1, (g == 1));
        checkOutput($sformatf("k%0d_c%0d_io_we", k, cyc), we, (cyc == we_at[k]));
        checkOutput($sformatf("k%0d_c%0d_busy", k, cyc), bz, !idle);
        checkOutput($sformatf("k%0d_c%0d_io_addr", k, cyc), ad, exp_addr[k]);
        checkOutput($sformatf("k%0d_c%0d_io_data", k, cyc), dt, exp_data[k]);
        checkOutput($sformatf("k%0d_c%0d_wr_cnt0", k, cyc), c0, cnt[k][0]);
        checkOutput($sformatf("k%0d_c%0d_wr_cnt1", k, cyc), c1, cnt[k][1]);
        if (g >= 0) begin
            accepted[k][g] = 1'b1;
            acc_cnt[k][g]++;
            exp_addr[k] = sa[k][g];
            exp_data[k] = sd[k][g];
            last_g[k]   = g;
            free_at[k]  = cyc + 2 + GAP_OF[k];
            if (addrLegal(sa[k][g])) begin
                we_at[k]  = cyc + 1;
                pend_m[k] = g;
            end
        end
    endtask

    task automatic applyStimulus();
        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (accepted[k][m]) begin
                    sv[k][m] = 1'b0;
                    accepted[k][m] = 1'b0;
                end
                if (!sv[k][m]) begin
                    if (quota[k][m] > 0) begin
                        quota[k][m]--;
                        seq++;
                        sv[k][m] = 1'b1;
                        sa[k][m] = use_bad[k][m] ? 32'h88 : (m == 1 ? 32'h84 : 32'h80);
                        sd[k][m] = 32'hA5A5_0000 + 32'(seq);
                        use_bad[k][m] = 1'b0;
                    end else if (rnd[k][m] && ($urandom_range(0, 1) == 1)) begin
                        sv[k][m] = 1'b1;
                        sa[k][m] = (m == 1 ? 32'h84 : 32'h80) | 32'($urandom_range(0, 3));
                        sd[k][m] = $urandom;
                    end
                end
            end
        end
    endtask

    task automatic runCycle();
        @(negedge io_clk);
        modelCheck(0);
        modelCheck(1);
        @(posedge io_clk);
        #1;
        cyc++;
        applyStimulus();
    endtask

    task automatic runN(input int n);
        for (int i = 0; i < n; i++) runCycle();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must collapse before any clock edge.
    task automatic doReset();
        for (int k = 0; k < 2; k++)
            for (int m = 0; m < 2; m++) sv[k][m] = 1'b0;
        #2;
        clrn = 1'b0;
        #1;
        checkOutput("rst_io_we_a", bus_a.io_we, 0);
        checkOutput("rst_busy_a", busy_a, 0);
        checkOutput("rst_cnt0_a", cnt0_a, 0);
        checkOutput("rst_cnt1_a", cnt1_a, 0);
        checkOutput("rst_io_addr_a", bus_a.io_addr, 0);
        checkOutput("rst_io_data_a", bus_a.io_data, 0);
        checkOutput("rst_io_we_b", bus_b.io_we, 0);
        checkOutput("rst_busy_b", busy_b, 0);
        checkOutput("rst_err_a", err_addr_a, 0);
        @(posedge io_clk);
        #1;
        cyc++;
        clrn = 1'b1;
        modelReset();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t0, guard, n_we, saved;
        clrn = 1'b0;
        modelReset();
        @(posedge io_clk);
        #1;
        doReset();

        $display("[TB] single CPU write after reset, GAP=2");
        t0 = cyc;
        quota[0][0] = 1;
        applyStimulus();
        busy_cyc_a = 0;
        runN(6);
        checkOutput("t1_ready_cycle", qget(gnt_cyc_a, 0) - t0, 0);
        checkOutput("t1_we_cycle", qget(we_log_a, 0) - t0, 1);
        checkOutput("t1_busy_cycles", busy_cyc_a, 3);
        checkOutput("t1_cnt0", cnt0_a, 1);
        checkOutput("t1_io_addr", bus_a.io_addr, 32'h80);
        checkOutput("t1_io_data", bus_a.io_data, 32'hA5A5_0001);

        $display("[TB] both masters contending (a) and continuous aux writes with GAP=0 (b)");
        doReset();
        we_log_a.delete(); we_log_b.delete(); gnt_log_a.delete(); gnt_cyc_a.delete();
        quota[0][0] = 2; quota[0][1] = 2; quota[1][1] = 3;
        applyStimulus();
        guard = 0;
        while ((acc_cnt[0][0] + acc_cnt[0][1] < 4 || acc_cnt[1][1] < 3) && guard < 60) begin
            runCycle();
            guard++;
        end
        checkOutput("t2_accept_bound", acc_cnt[0][0] + acc_cnt[0][1] + acc_cnt[1][1], 7);
        runN(6);
        checkOutput("t2_grants", gnt_log_a.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t2_grant%0d", i), qget(gnt_log_a, i), i % 2);
        for (int i = 1; i < 4; i++)
            checkOutput($sformatf("t2_we_gap%0d", i), qget(we_log_a, i) - qget(we_log_a, i - 1), 4);
        checkOutput("t2_cnt0", cnt0_a, 2);
        checkOutput("t2_cnt1", cnt1_a, 2);
        for (int i = 1; i < 3; i++)
            checkOutput($sformatf("t3_we_gap%0d", i), qget(we_log_b, i) - qget(we_log_b, i - 1), 2);
        checkOutput("t3_cnt1", cnt1_b, 3);

        $display("[TB] reset during WRITE, then tie after release");
        quota[0][0] = 1;
        applyStimulus();
        runCycle();
        checkOutput("t4_we_before_reset", bus_a.io_we, 1);
        doReset();
        quota[0][0] = 1; quota[0][1] = 1;
        applyStimulus();
        #1;
        checkOutput("t4_tie_ready0", bus_a.req0_ready, 1);
        checkOutput("t4_tie_ready1", bus_a.req1_ready, 0);
        runN(10);

        $display("[TB] counter wrap on 4-bit instance");
        quota[1][0] = 16;
        applyStimulus();
        guard = 0;
        while (acc_cnt[1][0] < 16 && guard < 80) begin
            runCycle();
            guard++;
        end
        checkOutput("wrap_accept_bound", acc_cnt[1][0], 16);
        runN(4);
        checkOutput("wrap_cnt0_b", cnt0_b, 0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 2; k++)
            for (int m = 0; m < 2; m++) rnd[k][m] = 1'b1;
        runN(1500);
        for (int k = 0; k < 2; k++)
            for (int m = 0; m < 2; m++) rnd[k][m] = 1'b0;
        runN(12);
        checkOutput("rand_cnt0_a", cnt0_a, cnt[0][0]);
        checkOutput("rand_cnt1_a", cnt1_a, cnt[0][1]);
        checkOutput("rand_cnt0_b", cnt0_b, cnt[1][0]);
        checkOutput("rand_cnt1_b", cnt1_b, cnt[1][1]);

`ifdef IO_ADDR_CHECK_EN
        $display("[TB] illegal output-port address");
        n_we  = we_log_a.size();
        saved = cnt[0][0];
        use_bad[0][0] = 1'b1;
        quota[0][0] = 1;
        applyStimulus();
        runN(6);
        checkOutput("chk_err_set", err_addr_a, 1);
        checkOutput("chk_cnt_kept", cnt0_a, saved);
        checkOutput("chk_no_we", we_log_a.size(), n_we);
        checkOutput("chk_addr_captured", bus_a.io_addr, 32'h88);
        err_clr_a = 1'b1;
        runCycle();
        err_clr_a = 1'b0;
        checkOutput("chk_err_clr", err_addr_a, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
